// File: rtl/huffman_decode.sv
// Serial Huffman decoder: latches a 10-entry code table, then resolves one bit per valid cycle
// into 4-bit symbols; a symbol pulses one cycle after its last bit, and DONE/ERR hold until RST.
module huffman_decode #(
   parameter int NUM_CHARS = 256,
   parameter int MAX_LEN   = 9
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         table_over,
   input  logic [10*(4+MAX_LEN)-1:0]    CODE_TABLE_IN,
   input  logic                         BIT_IN,
   input  logic                         BIT_VALID,
   output logic [3:0]                   SYMBOL_OUT,
   output logic                         SYMBOL_VALID,
   output logic [4*NUM_CHARS-1:0]       CHARACTER_OUT,
   output logic                         decode_over,
   output logic                         ERROR
);

   localparam int EW = 4 + MAX_LEN;
   localparam int CW = $clog2(NUM_CHARS + 1);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_DONE, S_ERR} state_t;

   state_t                    r_state, w_state_n;
   logic [10*EW-1:0]          r_table;
   logic [MAX_LEN-1:0]        r_acc;
   logic [3:0]                r_len;
   logic [CW-1:0]             r_count;
   logic [3:0]                r_sym;
   logic                      r_sym_vld;
   logic [4*NUM_CHARS-1:0]    r_chars;

   logic [3:0]                w_len_k  [10];
   logic [MAX_LEN-1:0]        w_code_k [10];
   logic [MAX_LEN-1:0]        w_acc_n;
   logic [MAX_LEN-1:0]        w_mask;
   logic [3:0]                w_len_n;
   logic [CW-1:0]             w_count_n;
   logic                      w_fire;
   logic                      w_hit;
   logic [3:0]                w_sym;

   for (genvar g = 0; g < 10; g++) begin : g_ent
      assign w_len_k[g]  = r_table[EW*g+MAX_LEN +: 4];
      assign w_code_k[g] = r_table[EW*g +: MAX_LEN];
   end

   assign w_len_n   = r_len + 4'd1;
   assign w_acc_n   = {r_acc[MAX_LEN-2:0], BIT_IN};
   assign w_count_n = r_count + CW'(1);
   assign w_fire    = (r_state == S_DECODE) && BIT_VALID;

   // Scan from the top so the lowest matching entry wins on a non-prefix table.
   always_comb begin
      w_mask = '0;
      w_hit  = 1'b0;
      w_sym  = 4'd0;
      for (int b = 0; b < MAX_LEN; b++) begin
         w_mask[b] = (b < int'(w_len_n));
      end
      for (int k = 9; k >= 0; k--) begin
         if ((w_len_k[k] != 4'd0) && (w_len_k[k] <= 4'(MAX_LEN)) &&
             (w_len_k[k] == w_len_n) &&
             (((w_code_k[k] ^ w_acc_n) & w_mask) == '0)) begin
            w_hit = 1'b1;
            w_sym = 4'(k + 1);
         end
      end
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE: begin
            if (table_over) w_state_n = S_DECODE;
         end
         S_DECODE: begin
            if (BIT_VALID) begin
               if (w_hit && (w_count_n == CW'(NUM_CHARS)))
                  w_state_n = S_DONE;
               else if (!w_hit && (w_len_n == 4'(MAX_LEN)))
                  w_state_n = S_ERR;
            end
         end
         default: w_state_n = r_state;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_table   <= '0;
         r_acc     <= '0;
         r_len     <= '0;
         r_count   <= '0;
         r_sym     <= '0;
         r_sym_vld <= 1'b0;
         r_chars   <= '0;
      end else begin
         r_sym_vld <= 1'b0;
         if ((r_state == S_IDLE) && table_over) r_table <= CODE_TABLE_IN;
         if (w_fire) begin
            if (w_hit) begin
               r_sym     <= w_sym;
               r_sym_vld <= 1'b1;
               r_chars   <= {w_sym, r_chars[4*NUM_CHARS-1:4]};
               r_count   <= w_count_n;
               r_acc     <= '0;
               r_len     <= '0;
            end else if (w_len_n != 4'(MAX_LEN)) begin
               r_acc <= w_acc_n;
               r_len <= w_len_n;
            end
         end
      end
   end

   assign SYMBOL_OUT    = r_sym;
   assign SYMBOL_VALID  = r_sym_vld;
   assign CHARACTER_OUT = r_chars;
   assign decode_over   = (r_state == S_DONE);
   assign ERROR         = (r_state == S_ERR);

endmodule

// File: tb/tb_huffman_decode.sv
// Directed bench for huffman_decode: hand-built code tables, bit-serial stimulus, fixed expectations.
module tb_huffman_decode;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          table_over = 1'b0;
   logic [129:0]  CODE_TABLE_IN = '0;
   logic          BIT_IN = 1'b0;
   logic          BIT_VALID = 1'b0;
   logic [3:0]    SYMBOL_OUT;
   logic          SYMBOL_VALID;
   logic [1023:0] CHARACTER_OUT;
   logic          decode_over;
   logic          ERROR;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses   = 0;
   int p0;

   logic [129:0]  tbl_a;
   logic [129:0]  tbl_b;
   logic [1023:0] exp_val;

   huffman_decode dut (
      .CLK(CLK), .RST(RST), .table_over(table_over), .CODE_TABLE_IN(CODE_TABLE_IN),
      .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID), .SYMBOL_OUT(SYMBOL_OUT),
      .SYMBOL_VALID(SYMBOL_VALID), .CHARACTER_OUT(CHARACTER_OUT),
      .decode_over(decode_over), .ERROR(ERROR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      #2;
      if (SYMBOL_VALID) pulses++;
   end

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input logic b);
      @(negedge CLK);
      BIT_IN    = b;
      BIT_VALID = 1'b1;
   endtask

   task automatic idle();
      @(negedge CLK);
      BIT_VALID = 1'b0;
   endtask

   task automatic send_code(input int sym);
      if (sym == 10) begin
         for (int i = 0; i < 9; i++) send(1'b1);
      end else begin
         for (int i = 0; i < sym - 1; i++) send(1'b1);
         send(1'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST       = 1'b1;
      BIT_VALID = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // A valid 1 during the latch cycle must be ignored.
   task automatic load(input logic [129:0] t);
      @(negedge CLK);
      table_over    = 1'b1;
      CODE_TABLE_IN = t;
      BIT_IN        = 1'b1;
      BIT_VALID     = 1'b1;
      @(negedge CLK);
      table_over = 1'b0;
      BIT_VALID  = 1'b0;
   endtask

   initial begin
      tbl_a = '0;
      for (int k = 1; k <= 9; k++) tbl_a[13*(k-1) +: 13] = {4'(k), 9'((1 << k) - 2)};
      tbl_a[13*9 +: 13] = {4'd9, 9'h1FF};
      tbl_b = '0;
      tbl_b[12:0] = {4'd1, 9'd0};

      do_reset();
      check("rst_sym",   1024'(SYMBOL_OUT), 1024'(0));
      check("rst_vld",   1024'(SYMBOL_VALID), 1024'(0));
      check("rst_chars", CHARACTER_OUT, '0);
      check("rst_over",  1024'(decode_over), 1024'(0));
      check("rst_err",   1024'(ERROR), 1024'(0));

      load(tbl_a);
      send(1'b1);
      send(1'b0);
      check("gap_before_pulse", 1024'(SYMBOL_VALID), 1024'(0));
      idle();
      check("sym2_vld", 1024'(SYMBOL_VALID), 1024'(1));
      check("sym2_val", 1024'(SYMBOL_OUT), 1024'(2));
      idle();
      check("sym2_one_cycle", 1024'(SYMBOL_VALID), 1024'(0));
      check("sym_hold", 1024'(SYMBOL_OUT), 1024'(2));
      send_code(10); idle();
      check("sym10_val", 1024'(SYMBOL_OUT), 1024'(10));
      send_code(9); idle();
      check("sym9_val", 1024'(SYMBOL_OUT), 1024'(9));

      p0 = pulses;
      send(1'b1);
      idle(); idle(); idle();
      check("gap_no_pulse", 1024'(pulses - p0), 1024'(0));
      send(1'b0);
      idle();
      check("gap_pulse", 1024'(pulses - p0), 1024'(1));
      check("gap_sym", 1024'(SYMBOL_OUT), 1024'(2));

      for (int i = 0; i < 6; i++) send(1'b0);
      idle(); idle();
      check("ten_syms", 1024'(CHARACTER_OUT[1023:984]), 1024'(40'h1111_1129A2));

      do_reset();
      check("rst2_chars", CHARACTER_OUT, '0);
      check("rst2_sym",   1024'(SYMBOL_OUT), 1024'(0));
      check("rst2_over",  1024'(decode_over), 1024'(0));
      p0 = pulses;
      for (int i = 0; i < 4; i++) send(1'b0);
      idle(); idle();
      check("idle_bits_ignored", 1024'(pulses - p0), 1024'(0));

      load(tbl_a);
      p0 = pulses;
      for (int i = 0; i < 255; i++) send(1'b0);
      idle();
      check("pre_done_over", 1024'(decode_over), 1024'(0));
      check("pre_done_cnt",  1024'(pulses - p0), 1024'(255));
      send(1'b0);
      idle();
      check("done_vld",  1024'(SYMBOL_VALID), 1024'(1));
      check("done_over", 1024'(decode_over), 1024'(1));
      check("done_cnt",  1024'(pulses - p0), 1024'(256));
      exp_val = {256{4'h1}};
      check("all_ones", CHARACTER_OUT, exp_val);
      for (int i = 0; i < 5; i++) send(1'b0);
      idle(); idle();
      check("post_done_cnt",  1024'(pulses - p0), 1024'(256));
      check("post_done_over", 1024'(decode_over), 1024'(1));
      check("post_done_chars", CHARACTER_OUT, exp_val);

      do_reset();
      load(tbl_a);
      for (int r = 0; r < 64; r++) begin
         send_code(1); send_code(2); send_code(3); send_code(10);
      end
      idle(); idle();
      exp_val = {64{16'hA321}};
      check("mix_chars", CHARACTER_OUT, exp_val);
      check("mix_over",  1024'(decode_over), 1024'(1));
      check("mix_err",   1024'(ERROR), 1024'(0));

      do_reset();
      load(tbl_b);
      p0 = pulses;
      for (int i = 0; i < 8; i++) send(1'b1);
      idle();
      check("err_before", 1024'(ERROR), 1024'(0));
      send(1'b1);
      idle();
      check("err_set",   1024'(ERROR), 1024'(1));
      check("err_nopulse", 1024'(pulses - p0), 1024'(0));
      send(1'b0); send(1'b0);
      idle(); idle();
      check("err_ignored", 1024'(pulses - p0), 1024'(0));
      check("err_chars", CHARACTER_OUT, '0);
      check("err_held",  1024'(ERROR), 1024'(1));
      check("err_no_over", 1024'(decode_over), 1024'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
